// File: rtl/ddr3_reader_pkg.sv
// Shared FSM type and encoding constants for the DDR3 frame reader.
package ddr3_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DATA,
    S_DONE
  } reader_state_e;

  localparam logic [1:0] ST_BUF0 = 2'd0;
  localparam logic [1:0] ST_BUF1 = 2'd1;
  localparam logic [1:0] ST_IDLE = 2'd3;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/frame_fifo.sv
// First-word fall-through FIFO; o_free reports open slots so the reader can
// reserve space for a whole burst before it issues the read.
module frame_fifo #(
  parameter int FIFO_AW = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [FIFO_AW:0]  o_free
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LP_DEPTH = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // A pop in the same cycle frees a slot, so push at full is still legal.
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && ((r_count != LP_DEPTH) || w_pop);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_free  = LP_DEPTH - r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_frame_reader.sv
// Ping-pong frame reader: bursts one full frame out of DDR3 through Avalon-MM
// into a FWFT FIFO that feeds the pixel stream.
module ddr3_frame_reader
  import ddr3_reader_pkg::*;
#(
  parameter int BURST_MAX = 16,
  parameter int FIFO_AW   = 6,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       buffer_base,
  input  logic [31:0]       img_size,
  input  logic [31:0]       start_status,
  input  logic [1:0]        buffer_status,
  output logic [1:0]        state,
  output logic              img_end,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic [4:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              sof
);

  reader_state_e r_state;
  reader_state_e w_next;

  logic        r_last_buf;
  logic        r_cur_buf;
  logic [31:0] r_addr;
  logic [29:0] r_remaining;
  logic [4:0]  r_beats;
  logic [4:0]  r_blen;
  logic        r_first;

  logic              w_en;
  logic              w_sel;
  logic [29:0]       w_words;
  logic [4:0]        w_blen;
  logic [FIFO_AW:0]  w_free;
  logic              w_can_issue;
  logic              w_accept;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_pop;
  logic [DATA_W:0]   w_head;
  logic              w_unused;

  assign w_en        = start_status[0];
  assign w_sel       = ~r_last_buf;
  assign w_words     = img_size[31:2];
  assign w_blen      = (r_remaining >= 30'(BURST_MAX)) ? 5'(BURST_MAX) : r_remaining[4:0];
  assign w_can_issue = 32'(w_free) >= 32'(w_blen);
  assign w_accept    = (r_state == S_ISSUE) && w_can_issue && !avm_waitrequest;
  assign w_beat      = (r_state == S_DATA) && avm_readdatavalid;
  assign w_last_beat = w_beat && (r_beats == 5'd1);
  assign w_pop       = pix_valid && pix_ready;
  assign w_unused    = ^{start_status[31:1], img_size[1:0]};

  assign avm_address = r_addr;
  assign pix_data    = w_head[DATA_W-1:0];
  assign sof         = w_pop && w_head[DATA_W];

  // Each FIFO entry carries a start-of-frame tag so sof lines up with the
  // right word even when the previous frame is still draining.
  frame_fifo #(
    .FIFO_AW(FIFO_AW),
    .DATA_W (DATA_W + 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_beat),
    .i_data ({r_first, avm_readdata}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_valid(pix_valid),
    .o_free (w_free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    state          = ST_IDLE;
    img_end        = 1'b0;
    avm_read       = 1'b0;
    avm_burstcount = '0;
    case (r_state)
      S_IDLE: begin
        if (w_en) w_next = S_SELECT;
      end
      S_SELECT: begin
        if (!w_en)                    w_next = S_IDLE;
        else if (buffer_status[w_sel]) w_next = (w_words == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        state          = r_cur_buf ? ST_BUF1 : ST_BUF0;
        avm_read       = w_can_issue;
        avm_burstcount = w_blen;
        if (w_accept) w_next = S_DATA;
      end
      S_DATA: begin
        state = r_cur_buf ? ST_BUF1 : ST_BUF0;
        if (w_last_beat) w_next = (r_remaining == 30'd1) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        state   = r_cur_buf ? ST_BUF1 : ST_BUF0;
        img_end = 1'b1;
        w_next  = w_en ? S_SELECT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame parameters are captured once on leaving SELECT so register writes
  // mid-frame only affect the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_buf  <= 1'b1;
      r_cur_buf   <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_blen      <= '0;
      r_first     <= 1'b0;
    end else begin
      if ((r_state == S_SELECT) && w_en && buffer_status[w_sel]) begin
        r_cur_buf   <= w_sel;
        r_addr      <= w_sel ? (buffer_base + img_size) : buffer_base;
        r_remaining <= w_words;
        r_first     <= 1'b1;
      end
      if (w_accept) begin
        r_blen  <= w_blen;
        r_beats <= w_blen;
      end
      if (w_beat) begin
        r_beats     <= r_beats - 1'b1;
        r_remaining <= r_remaining - 1'b1;
        r_first     <= 1'b0;
      end
      if (w_last_beat) r_addr <= r_addr + 32'(r_blen) * 32'(BYTES_PER_WORD);
      if (r_state == S_DONE) r_last_buf <= r_cur_buf;
    end
  end

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Randomised scoreboard bench: a frame-level model predicts bursts, pixels and
// img_end; an Avalon memory model and pixel/img_end monitors check the DUT.
module tb_ddr3_frame_reader;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  bc;
    logic [1:0]  st;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    logic        sof;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] buffer_base = '0;
  logic [31:0] img_size = '0;
  logic [31:0] start_status = '0;
  logic [1:0]  buffer_status = '0;
  logic [1:0]  state;
  logic        img_end;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [4:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        sof;

  cmd_t        expCmd[$];
  pix_t        expPix[$];
  logic [1:0]  expEnd[$];
  logic [31:0] pendAddr[$];

  int checks = 0;
  int failures = 0;
  int stallCycles = 0;
  int randWait = 0;
  int readyMode = 1;
  int acceptCount = 0;
  logic modelLast = 1'b1;

  logic        prevRead = 1'b0;
  logic        prevWait = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [4:0]  prevBc = '0;
  logic [1:0]  prevState = '0;
  int          stallLeft = 0;
  cmd_t        curCmd;
  pix_t        curPix;

  ddr3_frame_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .buffer_base      (buffer_base),
    .img_size         (img_size),
    .start_status     (start_status),
    .buffer_status    (buffer_status),
    .state            (state),
    .img_end          (img_end),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .pix_data         (pix_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .sof              (sof)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the byte address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=event required=none", name);
  endtask

  // Frame-level model: predicts the buffer chosen, every burst and every pixel,
  // then presents the frame to the DUT by marking the buffer full.
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] size, input logic otherFull);
    logic        bufIdx;
    logic [31:0] a;
    int          rem;
    int          bl;
    pix_t        p;
    cmd_t        c;
    bufIdx = ~modelLast;
    a      = bufIdx ? base + size : base;
    rem    = int'(size >> 2);
    for (int i = 0; i < rem; i++) begin
      p.data = memWord(a + 32'(i * 4));
      p.sof  = (i == 0);
      expPix.push_back(p);
    end
    while (rem > 0) begin
      bl     = (rem > 16) ? 16 : rem;
      c.addr = a;
      c.bc   = 5'(bl);
      c.st   = {1'b0, bufIdx};
      expCmd.push_back(c);
      a   = a + 32'(bl * 4);
      rem = rem - bl;
    end
    expEnd.push_back({1'b0, bufIdx});
    modelLast = bufIdx;
    @(negedge clk);
    buffer_base   = base;
    img_size      = size;
    buffer_status = bufIdx ? {1'b1, otherFull} : {otherFull, 1'b1};
  endtask

  // The register block clears the full flag when img_end is seen.
  task automatic waitFrame();
    int n;
    n = 0;
    while (!img_end && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!img_end) failNow("img_end_timeout");
    buffer_status = 2'b00;
    n = 0;
    while (expPix.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pix_drained", 64'(expPix.size()), 64'd0);
  endtask

  // Avalon slave: accepts commands, checks them, holds stalls and returns beats.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prevRead && !prevWait) begin
          acceptCount++;
          if (expCmd.size() == 0) failNow("unexpected_burst");
          else begin
            curCmd = expCmd.pop_front();
            checkOutput("burst_addr", 64'(prevAddr), 64'(curCmd.addr));
            checkOutput("burst_count", 64'(prevBc), 64'(curCmd.bc));
            checkOutput("burst_state", 64'(prevState), 64'(curCmd.st));
          end
          for (int i = 0; i < int'(prevBc); i++) pendAddr.push_back(prevAddr + 32'(i * 4));
        end else if (prevRead && prevWait) begin
          checkOutput("stall_read", 64'(avm_read), 64'd1);
          checkOutput("stall_addr", 64'(avm_address), 64'(prevAddr));
          checkOutput("stall_count", 64'(avm_burstcount), 64'(prevBc));
        end
      end
      if (pendAddr.size() != 0 && (randWait == 0 || $urandom_range(3) != 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = memWord(pendAddr.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
      if (rst_n && avm_read) begin
        if (!prevRead) stallLeft = stallCycles;
        if (stallLeft > 0) begin
          avm_waitrequest = 1'b1;
          stallLeft--;
        end else avm_waitrequest = (randWait != 0) ? ($urandom_range(2) == 0) : 1'b0;
      end else avm_waitrequest = 1'(($urandom_range(1)));
      prevRead  = rst_n && avm_read;
      prevWait  = avm_waitrequest;
      prevAddr  = avm_address;
      prevBc    = avm_burstcount;
      prevState = state;
    end
  end

  // Pixel monitor: drives pix_ready and pops the expected-pixel queue per handshake.
  initial begin
    forever begin
      @(negedge clk);
      pix_ready = (readyMode == 2) ? 1'(($urandom_range(1))) : (readyMode == 1);
      #1;
      if (rst_n && pix_valid && pix_ready) begin
        if (expPix.size() == 0) failNow("unexpected_pixel");
        else begin
          curPix = expPix.pop_front();
          checkOutput("pix_data", 64'(pix_data), 64'(curPix.data));
          checkOutput("pix_sof", 64'(sof), 64'(curPix.sof));
        end
      end else if (rst_n && sof) failNow("sof_without_pop");
    end
  end

  // img_end monitor: each pulse must match a predicted frame and its buffer.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && img_end) begin
        if (expEnd.size() == 0) failNow("unexpected_img_end");
        else checkOutput("img_end_state", 64'(state), 64'(expEnd.pop_front()));
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int readSeen;
    int beats;
    int n;
    logic otherBit;
    logic [31:0] rb;
    logic [31:0] rs;

    #1;
    checkOutput("reset_state", 64'(state), 64'd3);
    checkOutput("reset_img_end", 64'(img_end), 64'd0);
    checkOutput("reset_read", 64'(avm_read), 64'd0);
    checkOutput("reset_addr", 64'(avm_address), 64'd0);
    checkOutput("reset_bc", 64'(avm_burstcount), 64'd0);
    checkOutput("reset_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("reset_sof", 64'(sof), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_status = 32'hFFFF_FFF1;

    $display("[TB] frame from buffer0");
    applyStimulus(32'h1000_0000, 32'd256, 1'b0);
    waitFrame();

    $display("[TB] buffer1 empty, buffer0 full: reader must wait");
    buffer_status = 2'b01;
    readSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (avm_read) readSeen++;
    end
    checkOutput("pingpong_no_read", 64'(readSeen), 64'd0);
    checkOutput("pingpong_idle_state", 64'(state), 64'd3);

    $display("[TB] ping-pong to buffer1");
    applyStimulus(32'h1000_0000, 32'd256, 1'b1);
    waitFrame();

    $display("[TB] partial burst with stalls");
    stallCycles = 5;
    applyStimulus(32'h2000_0040, 32'd84, 1'b0);
    waitFrame();
    stallCycles = 0;

    $display("[TB] backpressure");
    readyMode = 0;
    acceptCount = 0;
    applyStimulus(32'h3000_0000, 32'd320, 1'b0);
    repeat (400) @(negedge clk);
    checkOutput("bp_bursts_when_full", 64'(acceptCount), 64'd4);
    checkOutput("bp_pix_valid", 64'(pix_valid), 64'd1);
    readyMode = 1;
    waitFrame();
    checkOutput("bp_total_bursts", 64'(acceptCount), 64'd5);

    $display("[TB] zero-size frame");
    applyStimulus(32'h4000_0000, 32'd3, 1'b0);
    waitFrame();

    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      randWait  = 1;
      readyMode = 2;
      rb        = $urandom & 32'hFFFF_FFFC;
      rs        = (32'($urandom_range(100)) << 2) | 32'($urandom_range(3));
      otherBit  = 1'($urandom_range(1));
      applyStimulus(rb, rs, otherBit);
      waitFrame();
    end
    randWait  = 0;
    readyMode = 0;

    $display("[TB] reset mid-burst");
    applyStimulus(32'h5000_0000, 32'd256, 1'b0);
    beats = 0;
    n = 0;
    while (beats < 7 && n < 2000) begin
      @(posedge clk);
      if (avm_readdatavalid) beats++;
      n++;
    end
    checkOutput("rst_beats_seen", 64'(beats), 64'd7);
    @(negedge clk);
    rst_n = 1'b0;
    expCmd.delete();
    expPix.delete();
    expEnd.delete();
    buffer_status = 2'b00;
    modelLast = 1'b1;
    #1;
    checkOutput("rst_state", 64'(state), 64'd3);
    checkOutput("rst_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("rst_read", 64'(avm_read), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (pendAddr.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("straggler_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("straggler_state", 64'(state), 64'd3);
    readyMode = 1;
    applyStimulus(32'h6000_0100, 32'd64, 1'b0);
    waitFrame();

    repeat (10) @(negedge clk);
    checkOutput("end_cmd_queue", 64'(expCmd.size()), 64'd0);
    checkOutput("end_img_end_queue", 64'(expEnd.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
